// File: rtl/a8_pkg.sv
// Shared types and constants for the four-bit central register slice.
package a8_pkg;

  typedef logic [3:0] nibble_t;

  localparam nibble_t ALL_ONES = 4'hF;
  localparam nibble_t BIT1     = 4'h1;
  localparam nibble_t BIT2     = 4'h2;

  // Next register value: clear drops the old contents, write data is ORed in.
  // A write in the same cycle as a clear therefore leaves exactly the data.
  function automatic nibble_t reg_update(input nibble_t cur, input logic clr,
                                         input nibble_t data);
    return (clr ? 4'h0 : cur) | data;
  endfunction

endpackage

// File: rtl/a8_adder.sv
// Four-bit ripple adder for the slice: U = X + Y + cin with per-bit carries.
module a8_adder
  import a8_pkg::*;
(
  input  nibble_t x,
  input  nibble_t y,
  input  logic    cin,
  output nibble_t u,
  output nibble_t carry,
  output nibble_t xuy
);

  // Ripple the carry from bit 1 upward, recording the carry out of each bit.
  always_comb begin
    logic c;
    u     = '0;
    carry = '0;
    xuy   = x ^ y;
    c     = cin;
    for (int i = 0; i < 4; i++) begin
      u[i]     = x[i] ^ y[i] ^ c;
      c        = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      carry[i] = c;
    end
  end

endmodule

// File: rtl/a8_four_bit_slice.sv
// Bits 1-4 slice of the central register section: slice registers, the
// read/write bus, and the X+Y adder with carry chaining to the next slice.
module a8_four_bit_slice
  import a8_pkg::*;
(
  input  logic CLOCK,
  input  logic rst,
  input  logic WAG_, WLG_, WQG_, WZG_, WBG_, WG1G_, WG3G_, WG4G_,
  input  logic WALSG_, WYDG_, WYLOG_, WYDLOG_, A2XG_, L2GDG_, G2LSG_, MCRO_,
  input  logic RAG_, RLG_, RQG_, RZG_, RBLG_, RCG_, RGG_, RULOG_,
  input  logic CAG, CBG, CGG, CGA8, CLG1G, CQG, CUG, CZG,
  input  logic CH01, CH02, CH03, CH04,
  input  logic MDT01, MDT02, MDT03, MDT04,
  input  logic SA01, SA02, SA03, SA04,
  input  logic G01ED, G02ED, G03ED, G04ED, G05ED, G06ED,
  input  logic R15, R1C, RB1, RB2, MONEX, PONEX, TWOX, S08, S08_,
  input  logic CI01_, XUY05_, XUY06_, WL05_, WL06_, WL16_, G07_, SETAB_, SETCD_,
  output logic RL01_, RL02_, RL03_, RL04_,
  output logic WL01, WL02, WL03, WL04,
  output logic WL01_, WL02_, WL03_, WL04_,
  output logic MWL01, MWL02, MWL03, MWL04,
  output logic A01_, A02_, A03_, A04_,
  output logic L01_, L02_, L03_, L04_,
  output logic Z01_, Z02_, Z03_, Z04_,
  output logic G01, G02, G03, G04,
  output logic G01_, G02_, G03_, G04_,
  output logic GEM01, GEM02, GEM03, GEM04,
  output logic SUMA01_, SUMA02_, SUMA03_, SUMA04_,
  output logic SUMB01_, SUMB02_, SUMB03_, SUMB04_,
  output logic XUY01_, XUY02_, XUY03_, XUY04_,
  output logic CI02_, CI03_, CI04_, CI05_,
  output logic CO04, CO06,
  output logic G05_, G06_, S08A, S08A_, CLEARA, CLEARB, CLEARC, CLEARD
);

  nibble_t a, l, q, z, b, g, x, y;
  nibble_t ch, mdt, sa, g_ed;
  nibble_t rl, wl, u, carry, xuy_raw;
  nibble_t a_data, l_data, q_data, z_data, b_data, g_data, x_data, y_data;

  assign ch   = {CH04, CH03, CH02, CH01};
  assign mdt  = {MDT04, MDT03, MDT02, MDT01};
  assign sa   = {SA04, SA03, SA02, SA01};
  assign g_ed = {G04ED, G03ED, G02ED, G01ED};

  a8_adder u_adder (
    .x     (x),
    .y     (y),
    .cin   (~CI01_),
    .u     (u),
    .carry (carry),
    .xuy   (xuy_raw)
  );

  // Read bus: wired-OR of every enabled register source, channel data and constants.
  always_comb begin
    rl = ch | mdt;
    if (!RAG_)      rl = rl | a;
    if (!RLG_)      rl = rl | l;
    if (!RQG_)      rl = rl | q;
    if (!RZG_)      rl = rl | z;
    if (!RBLG_)     rl = rl | b;
    if (!RCG_)      rl = rl | ~b;
    if (!RGG_)      rl = rl | g;
    if (!RULOG_)    rl = rl | u;
    if (R15)        rl = rl | ALL_ONES;
    if (R1C || RB1) rl = rl | BIT1;
    if (RB2)        rl = rl | BIT2;
  end

  assign wl = rl;

  // Write data per register: all active strobes OR together, shifts pull edge bits from neighbours.
  always_comb begin
    a_data = '0;
    l_data = '0;
    q_data = '0;
    z_data = '0;
    b_data = '0;
    g_data = g_ed[3:0];
    x_data = '0;
    y_data = '0;
    if (!WAG_)                   a_data = a_data | wl;
    if (!WALSG_)                 a_data = a_data | {~WL06_, ~WL05_, wl[3], wl[2]};
    if (!WLG_)                   l_data = l_data | wl;
    if (!G2LSG_)                 l_data = l_data | g;
    if (!WQG_)                   q_data = wl;
    if (!WZG_)                   z_data = wl;
    if (!WBG_)                   b_data = wl;
    if (!WG1G_)                  g_data = g_data | wl;
    if (!WG3G_)                  g_data = g_data | {~WL05_, wl[3:1]};
    if (!WG4G_)                  g_data = g_data | {wl[2:0], ~WL16_};
    if (!L2GDG_)                 g_data = g_data | {l[2:0], ~G07_};
    if (!MCRO_)                  g_data = g_data | sa;
    if (!A2XG_)                  x_data = x_data | a;
    if (MONEX)                   x_data = x_data | ALL_ONES;
    if (PONEX)                   x_data = x_data | BIT1;
    if (TWOX)                    x_data = x_data | BIT2;
    if (!WYLOG_)                 y_data = y_data | wl;
    if (!WYDG_ || !WYDLOG_)      y_data = y_data | {wl[2:0], ~WL16_};
  end

  // Slice register file with asynchronous clear on rst.
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      a <= '0;
      l <= '0;
      q <= '0;
      z <= '0;
      b <= '0;
      g <= '0;
      x <= '0;
      y <= '0;
    end else begin
      a <= reg_update(a, CAG, a_data);
      l <= reg_update(l, CLG1G, l_data);
      q <= reg_update(q, CQG, q_data);
      z <= reg_update(z, CZG, z_data);
      b <= reg_update(b, CBG, b_data);
      g <= reg_update(g, CGG & CGA8, g_data);
      x <= reg_update(x, CUG, x_data);
      y <= reg_update(y, CUG, y_data);
    end
  end

  assign {RL04_, RL03_, RL02_, RL01_} = ~rl;
  assign {WL04, WL03, WL02, WL01}     = wl;
  assign {WL04_, WL03_, WL02_, WL01_} = ~wl;
  assign {MWL04, MWL03, MWL02, MWL01} = wl;

  assign {A04_, A03_, A02_, A01_} = ~a;
  assign {L04_, L03_, L02_, L01_} = ~l;
  assign {Z04_, Z03_, Z02_, Z01_} = ~z;
  assign {G04, G03, G02, G01}     = g;
  assign {G04_, G03_, G02_, G01_} = ~g;
  assign {GEM04, GEM03, GEM02, GEM01} = CGA8 ? 4'h0 : g;

  assign {SUMA04_, SUMA03_, SUMA02_, SUMA01_} = ~u;
  assign {SUMB04_, SUMB03_, SUMB02_, SUMB01_} = ~u;
  assign {XUY04_, XUY03_, XUY02_, XUY01_}     = ~xuy_raw;
  assign {CI05_, CI04_, CI03_, CI02_}         = ~carry;
  assign CO04 = carry[3];
  assign CO06 = carry[3] & ~XUY05_ & ~XUY06_;

  assign G05_   = ~G05ED;
  assign G06_   = ~G06ED;
  assign S08A   = S08;
  assign S08A_  = S08_;
  assign CLEARA = ~SETAB_;
  assign CLEARB = ~SETAB_;
  assign CLEARC = ~SETCD_;
  assign CLEARD = ~SETCD_;

endmodule

// File: tb/tb_a8_four_bit_slice.sv
// Directed self-checking bench for the four-bit central register slice.
module tb_a8_four_bit_slice;

  logic CLOCK, rst;
  logic WAG_, WLG_, WQG_, WZG_, WBG_, WG1G_, WG3G_, WG4G_;
  logic WALSG_, WYDG_, WYLOG_, WYDLOG_, A2XG_, L2GDG_, G2LSG_, MCRO_;
  logic RAG_, RLG_, RQG_, RZG_, RBLG_, RCG_, RGG_, RULOG_;
  logic CAG, CBG, CGG, CGA8, CLG1G, CQG, CUG, CZG;
  logic CH01, CH02, CH03, CH04, MDT01, MDT02, MDT03, MDT04;
  logic SA01, SA02, SA03, SA04;
  logic G01ED, G02ED, G03ED, G04ED, G05ED, G06ED;
  logic R15, R1C, RB1, RB2, MONEX, PONEX, TWOX, S08, S08_;
  logic CI01_, XUY05_, XUY06_, WL05_, WL06_, WL16_, G07_, SETAB_, SETCD_;

  logic RL01_, RL02_, RL03_, RL04_, WL01, WL02, WL03, WL04;
  logic WL01_, WL02_, WL03_, WL04_, MWL01, MWL02, MWL03, MWL04;
  logic A01_, A02_, A03_, A04_, L01_, L02_, L03_, L04_;
  logic Z01_, Z02_, Z03_, Z04_, G01, G02, G03, G04;
  logic G01_, G02_, G03_, G04_, GEM01, GEM02, GEM03, GEM04;
  logic SUMA01_, SUMA02_, SUMA03_, SUMA04_, SUMB01_, SUMB02_, SUMB03_, SUMB04_;
  logic XUY01_, XUY02_, XUY03_, XUY04_, CI02_, CI03_, CI04_, CI05_;
  logic CO04, CO06, G05_, G06_, S08A, S08A_, CLEARA, CLEARB, CLEARC, CLEARD;

  int checks = 0;
  int passed = 0;

  logic [3:0] rl_n, wl, wl_n, mwl, a_n, l_n, z_n, g_v, g_n, gem;
  logic [3:0] suma_n, sumb_n, xuy_n, ci_n;
  logic [5:0] levels;

  assign rl_n   = {RL04_, RL03_, RL02_, RL01_};
  assign wl     = {WL04, WL03, WL02, WL01};
  assign wl_n   = {WL04_, WL03_, WL02_, WL01_};
  assign mwl    = {MWL04, MWL03, MWL02, MWL01};
  assign a_n    = {A04_, A03_, A02_, A01_};
  assign l_n    = {L04_, L03_, L02_, L01_};
  assign z_n    = {Z04_, Z03_, Z02_, Z01_};
  assign g_v    = {G04, G03, G02, G01};
  assign g_n    = {G04_, G03_, G02_, G01_};
  assign gem    = {GEM04, GEM03, GEM02, GEM01};
  assign suma_n = {SUMA04_, SUMA03_, SUMA02_, SUMA01_};
  assign sumb_n = {SUMB04_, SUMB03_, SUMB02_, SUMB01_};
  assign xuy_n  = {XUY04_, XUY03_, XUY02_, XUY01_};
  assign ci_n   = {CI05_, CI04_, CI03_, CI02_};
  assign levels = {S08A, S08A_, CLEARA, CLEARB, CLEARC, CLEARD};

  a8_four_bit_slice dut (
    .CLOCK(CLOCK), .rst(rst),
    .WAG_(WAG_), .WLG_(WLG_), .WQG_(WQG_), .WZG_(WZG_), .WBG_(WBG_),
    .WG1G_(WG1G_), .WG3G_(WG3G_), .WG4G_(WG4G_), .WALSG_(WALSG_),
    .WYDG_(WYDG_), .WYLOG_(WYLOG_), .WYDLOG_(WYDLOG_), .A2XG_(A2XG_),
    .L2GDG_(L2GDG_), .G2LSG_(G2LSG_), .MCRO_(MCRO_),
    .RAG_(RAG_), .RLG_(RLG_), .RQG_(RQG_), .RZG_(RZG_), .RBLG_(RBLG_),
    .RCG_(RCG_), .RGG_(RGG_), .RULOG_(RULOG_),
    .CAG(CAG), .CBG(CBG), .CGG(CGG), .CGA8(CGA8), .CLG1G(CLG1G),
    .CQG(CQG), .CUG(CUG), .CZG(CZG),
    .CH01(CH01), .CH02(CH02), .CH03(CH03), .CH04(CH04),
    .MDT01(MDT01), .MDT02(MDT02), .MDT03(MDT03), .MDT04(MDT04),
    .SA01(SA01), .SA02(SA02), .SA03(SA03), .SA04(SA04),
    .G01ED(G01ED), .G02ED(G02ED), .G03ED(G03ED), .G04ED(G04ED),
    .G05ED(G05ED), .G06ED(G06ED),
    .R15(R15), .R1C(R1C), .RB1(RB1), .RB2(RB2), .MONEX(MONEX),
    .PONEX(PONEX), .TWOX(TWOX), .S08(S08), .S08_(S08_),
    .CI01_(CI01_), .XUY05_(XUY05_), .XUY06_(XUY06_), .WL05_(WL05_),
    .WL06_(WL06_), .WL16_(WL16_), .G07_(G07_), .SETAB_(SETAB_), .SETCD_(SETCD_),
    .RL01_(RL01_), .RL02_(RL02_), .RL03_(RL03_), .RL04_(RL04_),
    .WL01(WL01), .WL02(WL02), .WL03(WL03), .WL04(WL04),
    .WL01_(WL01_), .WL02_(WL02_), .WL03_(WL03_), .WL04_(WL04_),
    .MWL01(MWL01), .MWL02(MWL02), .MWL03(MWL03), .MWL04(MWL04),
    .A01_(A01_), .A02_(A02_), .A03_(A03_), .A04_(A04_),
    .L01_(L01_), .L02_(L02_), .L03_(L03_), .L04_(L04_),
    .Z01_(Z01_), .Z02_(Z02_), .Z03_(Z03_), .Z04_(Z04_),
    .G01(G01), .G02(G02), .G03(G03), .G04(G04),
    .G01_(G01_), .G02_(G02_), .G03_(G03_), .G04_(G04_),
    .GEM01(GEM01), .GEM02(GEM02), .GEM03(GEM03), .GEM04(GEM04),
    .SUMA01_(SUMA01_), .SUMA02_(SUMA02_), .SUMA03_(SUMA03_), .SUMA04_(SUMA04_),
    .SUMB01_(SUMB01_), .SUMB02_(SUMB02_), .SUMB03_(SUMB03_), .SUMB04_(SUMB04_),
    .XUY01_(XUY01_), .XUY02_(XUY02_), .XUY03_(XUY03_), .XUY04_(XUY04_),
    .CI02_(CI02_), .CI03_(CI03_), .CI04_(CI04_), .CI05_(CI05_),
    .CO04(CO04), .CO06(CO06), .G05_(G05_), .G06_(G06_), .S08A(S08A),
    .S08A_(S08A_), .CLEARA(CLEARA), .CLEARB(CLEARB), .CLEARC(CLEARC),
    .CLEARD(CLEARD)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Wait for the next rising edge, then step off it before driving or sampling.
  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic set_ch(input logic [3:0] v);
    {CH04, CH03, CH02, CH01} = v;
  endtask

  task automatic set_mdt(input logic [3:0] v);
    {MDT04, MDT03, MDT02, MDT01} = v;
  endtask

  task automatic set_sa(input logic [3:0] v);
    {SA04, SA03, SA02, SA01} = v;
  endtask

  // All strobes inactive, data and constants zero, neighbour lines idle.
  task automatic quiet();
    {WAG_, WLG_, WQG_, WZG_, WBG_, WG1G_, WG3G_, WG4G_} = 8'hFF;
    {WALSG_, WYDG_, WYLOG_, WYDLOG_, A2XG_, L2GDG_, G2LSG_, MCRO_} = 8'hFF;
    {RAG_, RLG_, RQG_, RZG_, RBLG_, RCG_, RGG_, RULOG_} = 8'hFF;
    {CAG, CBG, CGG, CGA8, CLG1G, CQG, CUG, CZG} = 8'h00;
    set_ch(4'h0);
    set_mdt(4'h0);
    set_sa(4'h0);
    {G01ED, G02ED, G03ED, G04ED, G05ED, G06ED} = 6'b0;
    {R15, R1C, RB1, RB2, MONEX, PONEX, TWOX, S08, S08_} = 9'b0;
    {CI01_, XUY05_, XUY06_, WL05_, WL06_, WL16_, G07_, SETAB_, SETCD_} = 9'h1FF;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (a_n !== 4'hF) $display("[TB] FAIL reset_a: got %b want %b", a_n, 4'hF); else passed++;
    checks++; if (g_v !== 4'h0) $display("[TB] FAIL reset_g: got %b want %b", g_v, 4'h0); else passed++;
    checks++; if (rl_n !== 4'hF) $display("[TB] FAIL reset_rl: got %b want %b", rl_n, 4'hF); else passed++;
    checks++; if (CO04 !== 1'b0) $display("[TB] FAIL reset_co04: got %b want %b", CO04, 1'b0); else passed++;
    checks++; if (suma_n !== 4'hF) $display("[TB] FAIL reset_suma: got %b want %b", suma_n, 4'hF); else passed++;
    checks++; if (xuy_n !== 4'hF) $display("[TB] FAIL reset_xuy: got %b want %b", xuy_n, 4'hF); else passed++;
    set_ch(4'hF);
    WAG_ = 1'b0;
    tick();
    checks++; if (a_n !== 4'hF) $display("[TB] FAIL reset_holds_a: got %b want %b", a_n, 4'hF); else passed++;
    quiet();
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    set_ch(4'b0101);
    WAG_ = 1'b0;
    tick();
    quiet();
    RAG_ = 1'b0;
    #1;
    checks++; if (a_n !== 4'b1010) $display("[TB] FAIL wr_a: got %b want %b", a_n, 4'b1010); else passed++;
    checks++; if (rl_n !== 4'b1010) $display("[TB] FAIL rd_rl: got %b want %b", rl_n, 4'b1010); else passed++;
    checks++; if (wl !== 4'b0101) $display("[TB] FAIL rd_wl: got %b want %b", wl, 4'b0101); else passed++;
    set_mdt(4'b1000);
    #1;
    checks++; if (rl_n !== 4'b0010) $display("[TB] FAIL rd_mdt: got %b want %b", rl_n, 4'b0010); else passed++;
    quiet();
  endtask

  task automatic test_add();
    MONEX  = 1'b1;
    WYLOG_ = 1'b0;
    set_ch(4'b0001);
    tick();
    quiet();
    #1;
    checks++; if (CO04 !== 1'b1) $display("[TB] FAIL add_co04: got %b want %b", CO04, 1'b1); else passed++;
    checks++; if (CI05_ !== 1'b0) $display("[TB] FAIL add_ci05: got %b want %b", CI05_, 1'b0); else passed++;
    checks++; if (ci_n !== 4'b0000) $display("[TB] FAIL add_ci_chain: got %b want %b", ci_n, 4'b0000); else passed++;
    checks++; if (suma_n !== 4'hF) $display("[TB] FAIL add_suma: got %b want %b", suma_n, 4'hF); else passed++;
    checks++; if (sumb_n !== 4'hF) $display("[TB] FAIL add_sumb: got %b want %b", sumb_n, 4'hF); else passed++;
    checks++; if (xuy_n !== 4'b0001) $display("[TB] FAIL add_xuy: got %b want %b", xuy_n, 4'b0001); else passed++;
    checks++; if (CO06 !== 1'b0) $display("[TB] FAIL add_co06_idle: got %b want %b", CO06, 1'b0); else passed++;
    XUY05_ = 1'b0;
    #1;
    checks++; if (CO06 !== 1'b0) $display("[TB] FAIL add_co06_half: got %b want %b", CO06, 1'b0); else passed++;
    XUY06_ = 1'b0;
    #1;
    checks++; if (CO06 !== 1'b1) $display("[TB] FAIL add_co06: got %b want %b", CO06, 1'b1); else passed++;
    quiet();
    CI01_  = 1'b0;
    RULOG_ = 1'b0;
    #1;
    checks++; if (suma_n !== 4'b1110) $display("[TB] FAIL add_cin_sum: got %b want %b", suma_n, 4'b1110); else passed++;
    checks++; if (rl_n !== 4'b1110) $display("[TB] FAIL add_rd_u: got %b want %b", rl_n, 4'b1110); else passed++;
    quiet();
    CUG = 1'b1;
    tick();
    quiet();
    #1;
    checks++; if (xuy_n !== 4'hF) $display("[TB] FAIL add_cug_xuy: got %b want %b", xuy_n, 4'hF); else passed++;
    checks++; if (CO04 !== 1'b0) $display("[TB] FAIL add_cug_co04: got %b want %b", CO04, 1'b0); else passed++;
    A2XG_ = 1'b0;
    TWOX  = 1'b1;
    tick();
    quiet();
    WYDG_ = 1'b0;
    WL16_ = 1'b0;
    set_ch(4'b0100);
    tick();
    quiet();
    #1;
    checks++; if (xuy_n !== 4'b0001) $display("[TB] FAIL add_a2x_xuy: got %b want %b", xuy_n, 4'b0001); else passed++;
    checks++; if (CO04 !== 1'b1) $display("[TB] FAIL add_a2x_co04: got %b want %b", CO04, 1'b1); else passed++;
  endtask

  task automatic test_shifts();
    set_ch(4'b1010);
    WG4G_ = 1'b0;
    WL16_ = 1'b0;
    tick();
    quiet();
    #1;
    checks++; if (g_v !== 4'b0101) $display("[TB] FAIL shl_g: got %b want %b", g_v, 4'b0101); else passed++;
    checks++; if (g_n !== 4'b1010) $display("[TB] FAIL shl_g_n: got %b want %b", g_n, 4'b1010); else passed++;
    checks++; if (gem !== 4'b0101) $display("[TB] FAIL shl_gem: got %b want %b", gem, 4'b0101); else passed++;
    set_ch(4'b1010);
    WG3G_ = 1'b0;
    WL05_ = 1'b0;
    tick();
    quiet();
    #1;
    checks++; if (g_v !== 4'b1101) $display("[TB] FAIL shr_g: got %b want %b", g_v, 4'b1101); else passed++;
    CGA8 = 1'b1;
    #1;
    checks++; if (gem !== 4'b0000) $display("[TB] FAIL gem_mask: got %b want %b", gem, 4'b0000); else passed++;
    CGA8 = 1'b0;
    CGG  = 1'b1;
    tick();
    #1;
    checks++; if (g_v !== 4'b1101) $display("[TB] FAIL g_half_clear: got %b want %b", g_v, 4'b1101); else passed++;
    CGA8 = 1'b1;
    tick();
    quiet();
    #1;
    checks++; if (g_v !== 4'b0000) $display("[TB] FAIL g_clear: got %b want %b", g_v, 4'b0000); else passed++;
    G02ED = 1'b1;
    tick();
    quiet();
    #1;
    checks++; if (g_v !== 4'b0010) $display("[TB] FAIL g_edit: got %b want %b", g_v, 4'b0010); else passed++;
    G05ED = 1'b1;
    G06ED = 1'b1;
    #1;
    checks++; if ({G05_, G06_} !== 2'b00) $display("[TB] FAIL g56_buf: got %b want %b", {G05_, G06_}, 2'b00); else passed++;
    quiet();
  endtask

  task automatic test_l_path();
    CGG  = 1'b1;
    CGA8 = 1'b1;
    set_ch(4'b0110);
    WLG_ = 1'b0;
    tick();
    quiet();
    #1;
    checks++; if (l_n !== 4'b1001) $display("[TB] FAIL l_write: got %b want %b", l_n, 4'b1001); else passed++;
    L2GDG_ = 1'b0;
    G07_   = 1'b0;
    tick();
    quiet();
    #1;
    checks++; if (g_v !== 4'b1101) $display("[TB] FAIL l2g_shift: got %b want %b", g_v, 4'b1101); else passed++;
    G2LSG_ = 1'b0;
    tick();
    quiet();
    #1;
    checks++; if (l_n !== 4'b0000) $display("[TB] FAIL g2l_or: got %b want %b", l_n, 4'b0000); else passed++;
    RGG_ = 1'b0;
    #1;
    checks++; if (wl !== 4'b1101) $display("[TB] FAIL rd_g: got %b want %b", wl, 4'b1101); else passed++;
    quiet();
    set_ch(4'b1001);
    WZG_ = 1'b0;
    tick();
    quiet();
    RZG_ = 1'b0;
    #1;
    checks++; if (z_n !== 4'b0110) $display("[TB] FAIL z_write: got %b want %b", z_n, 4'b0110); else passed++;
    checks++; if (wl !== 4'b1001) $display("[TB] FAIL rd_z: got %b want %b", wl, 4'b1001); else passed++;
    quiet();
    set_ch(4'b0111);
    WQG_ = 1'b0;
    tick();
    quiet();
    RQG_ = 1'b0;
    #1;
    checks++; if (wl !== 4'b0111) $display("[TB] FAIL rd_q: got %b want %b", wl, 4'b0111); else passed++;
    quiet();
    CLG1G = 1'b1;
    tick();
    quiet();
    RLG_ = 1'b0;
    #1;
    checks++; if (l_n !== 4'hF) $display("[TB] FAIL l_clear: got %b want %b", l_n, 4'hF); else passed++;
    checks++; if (wl !== 4'h0) $display("[TB] FAIL rd_l_empty: got %b want %b", wl, 4'h0); else passed++;
    quiet();
  endtask

  task automatic test_clear_priority();
    set_ch(4'hF);
    WAG_ = 1'b0;
    tick();
    #1;
    checks++; if (a_n !== 4'h0) $display("[TB] FAIL a_all_ones: got %b want %b", a_n, 4'h0); else passed++;
    CAG = 1'b1;
    set_ch(4'b0010);
    tick();
    quiet();
    #1;
    checks++; if (a_n !== 4'b1101) $display("[TB] FAIL clr_and_write: got %b want %b", a_n, 4'b1101); else passed++;
    CAG = 1'b1;
    tick();
    quiet();
    #1;
    checks++; if (a_n !== 4'hF) $display("[TB] FAIL clr_only: got %b want %b", a_n, 4'hF); else passed++;
    WAG_   = 1'b0;
    WALSG_ = 1'b0;
    WL05_  = 1'b0;
    set_ch(4'b0100);
    tick();
    quiet();
    #1;
    checks++; if (a_n !== 4'b1010) $display("[TB] FAIL a_two_writes: got %b want %b", a_n, 4'b1010); else passed++;
  endtask

  task automatic test_constants();
    set_ch(4'b0011);
    WBG_ = 1'b0;
    tick();
    quiet();
    RCG_ = 1'b0;
    R1C  = 1'b1;
    #1;
    checks++; if (rl_n !== 4'b0010) $display("[TB] FAIL cmp_rl: got %b want %b", rl_n, 4'b0010); else passed++;
    checks++; if (wl !== 4'b1101) $display("[TB] FAIL cmp_wl: got %b want %b", wl, 4'b1101); else passed++;
    checks++; if (wl_n !== 4'b0010) $display("[TB] FAIL cmp_wl_n: got %b want %b", wl_n, 4'b0010); else passed++;
    checks++; if (mwl !== 4'b1101) $display("[TB] FAIL cmp_mwl: got %b want %b", mwl, 4'b1101); else passed++;
    quiet();
    RBLG_ = 1'b0;
    #1;
    checks++; if (wl !== 4'b0011) $display("[TB] FAIL rd_b: got %b want %b", wl, 4'b0011); else passed++;
    quiet();
    RB2 = 1'b1;
    #1;
    checks++; if (wl !== 4'b0010) $display("[TB] FAIL const_rb2: got %b want %b", wl, 4'b0010); else passed++;
    quiet();
    RB1 = 1'b1;
    #1;
    checks++; if (wl !== 4'b0001) $display("[TB] FAIL const_rb1: got %b want %b", wl, 4'b0001); else passed++;
    quiet();
    R15 = 1'b1;
    #1;
    checks++; if (wl !== 4'hF) $display("[TB] FAIL const_r15: got %b want %b", wl, 4'hF); else passed++;
    quiet();
    S08    = 1'b1;
    S08_   = 1'b0;
    SETCD_ = 1'b0;
    #1;
    checks++; if (levels !== 6'b100011) $display("[TB] FAIL levels_cd: got %b want %b", levels, 6'b100011); else passed++;
    S08    = 1'b0;
    S08_   = 1'b1;
    SETCD_ = 1'b1;
    SETAB_ = 1'b0;
    #1;
    checks++; if (levels !== 6'b011100) $display("[TB] FAIL levels_ab: got %b want %b", levels, 6'b011100); else passed++;
    quiet();
  endtask

  task automatic test_reset_mid_cycle();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (a_n !== 4'hF) $display("[TB] FAIL async_a: got %b want %b", a_n, 4'hF); else passed++;
    checks++; if (g_v !== 4'h0) $display("[TB] FAIL async_g: got %b want %b", g_v, 4'h0); else passed++;
    #2;
    rst = 1'b0;
    set_ch(4'b0011);
    WAG_ = 1'b0;
    tick();
    quiet();
    #1;
    checks++; if (a_n !== 4'b1100) $display("[TB] FAIL after_reset_a: got %b want %b", a_n, 4'b1100); else passed++;
    set_sa(4'b1001);
    MCRO_ = 1'b0;
    tick();
    quiet();
    #1;
    checks++; if (g_v !== 4'b1001) $display("[TB] FAIL mcro_g: got %b want %b", g_v, 4'b1001); else passed++;
  endtask

  initial begin
    rst = 1'b0;
    quiet();
    #1;
    test_reset();
    test_write_read();
    test_add();
    test_shifts();
    test_l_path();
    test_clear_priority();
    test_constants();
    test_reset_mid_cycle();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/a8_four_bit_slice.md
Name: a8_four_bit_slice

Overview:
- Bits 1-4 slice of the central register section. Holds slice copies of the A, L, Q, Z, B, G, X and Y registers.
- Drives the slice read bus (RL) and write bus (WL) and adds X+Y with carry chaining to the next slice.
- Clocked, synchronous abstraction of a gate-level four-bit module; multiple instances tile a full word.

Parameters:
- none (slice width fixed at 4)

Ports:
- CLOCK  input  1  single clock, rising edge
- rst  input  1  asynchronous active-high reset
- WAG_ WLG_ WQG_ WZG_ WBG_ WG1G_ WG3G_ WG4G_ WALSG_ WYDG_ WYLOG_ WYDLOG_ A2XG_ L2GDG_ G2LSG_ MCRO_  input  1 each  write strobes, active-low
- RAG_ RLG_ RQG_ RZG_ RBLG_ RCG_ RGG_ RULOG_  input  1 each  read strobes, active-low
- CAG CBG CGG CGA8 CLG1G CQG CUG CZG  input  1 each  clear strobes, active-high
- CH01..CH04, MDT01..MDT04, SA01..SA04, G01ED..G06ED  input  1 each  channel, external data, sense amp, edit bits
- R15 R1C RB1 RB2 MONEX PONEX TWOX S08 S08_  input  1 each  constants and levels
- CI01_ XUY05_ XUY06_ WL05_ WL06_ WL16_ G07_ SETAB_ SETCD_  input  1 each  neighbour-slice signals, active-low
- RL01_..RL04_, WL01..WL04, WL01_..WL04_, MWL01..MWL04  output  1 each  read bus, write bus, write-bus monitor
- A01_..A04_, L01_..L04_, Z01_..Z04_, G01..G04, G01_..G04_, GEM01..GEM04  output  1 each  register views
- SUMA01_..SUMA04_, SUMB01_..SUMB04_, XUY01_..XUY04_, CI02_..CI05_, CO04 CO06  output  1 each  adder
- G05_ G06_ S08A S08A_ CLEARA CLEARB CLEARC CLEARD  output  1 each  buffered levels

Behaviour:
- Read bus RL[n] (combinational OR of all sources):
  - A if RAG_=0, L if RLG_=0, Q if RQG_=0, Z if RZG_=0, B if RBLG_=0, ~B if RCG_=0, G if RGG_=0, U if RULOG_=0.
  - CH0n and MDT0n, always.
  - R15 sets bits 1-4; R1C and RB1 set bit 1; RB2 sets bit 2.
  - Outputs: RL0n_ = ~RL[n]; WL = RL; WL0n_ = ~WL; MWL = WL.
- Register update rule on each rising CLOCK: next = (clear ? 0 : reg) | (write ? data : 0). A write and a clear in the same cycle yields data. Several writes to one register in the same cycle OR together.
- A: clear CAG.
  - WAG_ loads WL.
  - WALSG_ loads WL shifted down two: A1=WL3, A2=WL4, A3=~WL05_, A4=~WL06_.
- L: clear CLG1G.
  - WLG_ loads WL.
  - G2LSG_ loads G.
- Q: clear CQG; write WQG_. Z: clear CZG; write WZG_. B: clear CBG; write WBG_.
- G: clear when CGG=1 and CGA8=1.
  - WG1G_ loads WL.
  - WG3G_ loads WL>>1, bit4 = ~WL05_.
  - WG4G_ loads WL<<1, bit1 = ~WL16_.
  - L2GDG_ loads L<<1, bit1 = ~G07_.
  - MCRO_ loads SA01..04.
  - G0nED ORs into G bit n every cycle.
- X, Y: CUG clears both.
  - A2XG_ loads A into X. MONEX sets X=1111; PONEX sets X bit1; TWOX sets X bit2.
  - WYLOG_ loads WL into Y.
  - WYDG_ and WYDLOG_ load WL<<1 into Y, bit1 = ~WL16_.
- Adder (combinational):
  - U = X + Y + cin, 4 bits, cin = ~CI01_.
  - CI0(n+1)_ = ~carry out of bit n; CO04 = carry out of bit 4; CI05_ = ~CO04.
  - CO06 = CO04 & ~XUY05_ & ~XUY06_.
  - XUY0n_ = ~(X[n]^Y[n]); SUMA0n_ = SUMB0n_ = ~U[n].
- Register view outputs:
  - A0n_ = ~A; L0n_ = ~L; Z0n_ = ~Z; G0n = G; G0n_ = ~G.
  - GEM0n = G0n when CGA8=0, else 0.
- Buffered levels:
  - G05_ = ~G05ED; G06_ = ~G06ED.
  - S08A = S08; S08A_ = S08_.
  - CLEARA = CLEARB = ~SETAB_; CLEARC = CLEARD = ~SETCD_.
- Reset (rst=1, asynchronous): all registers = 0. All outputs then follow the combinational rules with zero registers. Reset asserted mid-cycle overrides any write.
- Latency: register writes visible on outputs one clock after the strobe; bus and adder outputs are zero-latency.

Decomposition:
- Package a8_pkg: typedef nibble_t (4-bit); constants ALL_ONES=4'hF, BIT1=4'h1, BIT2=4'h2.
- One sub-module: a8_adder (X, Y, cin → U, per-bit carries, XUY).

Test Plan:
- Reset: rst=1, then all strobes inactive → A01_..A04_=1, G01..G04=0, RL0n_=1, CO04=0.
- Write/read: CH=0101, WAG_=0 for one clock, then RAG_=0 with CH=0 → A01_..A04_ show A=0101, RL01_..RL04_ = 1010.
- Add: X=1111 (MONEX), Y=0001 (WYLOG_ with CH=0001), CI01_=1 → U=0000, CO04=1, CI05_=0. Add XUY05_=XUY06_=0 → CO06=1.
- Shifts: WL=1010, WG4G_=0, WL16_=0 → G=0101. Then WG3G_=0 with WL=1010, WL05_=0 → G=1101.
- Clear vs write priority: A=1111, CAG=1 and WAG_=0 with WL=0010 in the same cycle → A=0010. CAG alone → A=0000.
- Constants/complement: B=0011, RCG_=0, R1C=1, all else quiet → RL=1101, WL01..04=1101, MWL matches.
